// File: rtl/sound_mixer.sv
// Multi-channel gain mixer: snapshots a frame, accumulates one channel per clock,
// then scales back from Q2.(GAIN_W-2) and saturates into a registered output sample.
module sound_mixer #(
    parameter int unsigned       NUM_CH   = 4,
    parameter int unsigned       IN_W     = 16,
    parameter int unsigned       GAIN_W   = 8,
    parameter int unsigned       OUT_W    = 16,
    parameter logic [GAIN_W-1:0] GAIN_RST = 8'h40
) (
    input  logic                       clk_sys,
    input  logic                       reset,
    input  logic                       sample_ce,
    input  logic [NUM_CH*IN_W-1:0]     in_data,
    input  logic [NUM_CH-1:0]          mute,
    input  logic                       gain_wr,
    input  logic [$clog2(NUM_CH)-1:0]  gain_addr,
    input  logic [GAIN_W-1:0]          gain_din,
    input  logic                       clr_flags,
    output logic signed [OUT_W-1:0]    out_sample,
    output logic                       out_valid,
    output logic                       busy,
    output logic                       clip,
    output logic                       overrun
);

    localparam int unsigned AW     = $clog2(NUM_CH);
    localparam int unsigned PROD_W = IN_W + GAIN_W + 1;
    localparam int unsigned ACC_W  = PROD_W + AW;
    localparam int unsigned SHIFT  = GAIN_W - 2;

    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        {{(ACC_W - OUT_W + 1){1'b1}}, {(OUT_W - 1){1'b0}}};

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StAcc  = 2'd1;
    localparam logic [1:0] StOut  = 2'd2;

    logic [1:0]                state_q, state_d;
    logic [AW-1:0]             ch_q, ch_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic [GAIN_W-1:0]         gain_q [NUM_CH];
    logic [GAIN_W-1:0]         gain_d [NUM_CH];
    logic [GAIN_W-1:0]         fgain_q [NUM_CH];
    logic signed [IN_W-1:0]    samp_q [NUM_CH];
    logic [NUM_CH-1:0]         fmute_q;
    logic signed [OUT_W-1:0]   out_sample_q;
    logic                      out_valid_q;
    logic                      clip_q;
    logic                      overrun_q;

    logic signed [PROD_W-1:0]  prod;
    logic signed [PROD_W-1:0]  addend;
    logic signed [ACC_W-1:0]   shifted;
    logic signed [OUT_W-1:0]   result;
    logic                      sat;
    logic                      accept;
    logic                      ovr_event;

    assign accept    = (state_q == StIdle) && sample_ce;
    assign ovr_event = (state_q != StIdle) && sample_ce;

    // Live gain registers; out-of-range addresses match no entry and are dropped.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            gain_d[i] = gain_q[i];
            if (gain_wr && (gain_addr == AW'(i))) begin
                gain_d[i] = gain_din;
            end
        end
    end

    always_comb begin
        prod   = $signed(PROD_W'(samp_q[ch_q])) * $signed(PROD_W'({1'b0, fgain_q[ch_q]}));
        addend = fmute_q[ch_q] ? '0 : prod;
    end

    always_comb begin
        shifted = acc_q >>> SHIFT;
        sat     = 1'b0;
        result  = shifted[OUT_W-1:0];
        if (shifted > SAT_MAX) begin
            result = SAT_MAX[OUT_W-1:0];
            sat    = 1'b1;
        end else if (shifted < SAT_MIN) begin
            result = SAT_MIN[OUT_W-1:0];
            sat    = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        acc_d   = acc_q;
        unique case (state_q)
            StIdle: begin
                if (sample_ce) begin
                    state_d = StAcc;
                    ch_d    = '0;
                    acc_d   = '0;
                end
            end
            StAcc: begin
                acc_d = acc_q + ACC_W'(addend);
                if (ch_q == AW'(NUM_CH - 1)) begin
                    state_d = StOut;
                end else begin
                    ch_d = ch_q + AW'(1);
                end
            end
            StOut:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q      <= StIdle;
            ch_q         <= '0;
            acc_q        <= '0;
            fmute_q      <= '0;
            out_sample_q <= '0;
            out_valid_q  <= 1'b0;
            clip_q       <= 1'b0;
            overrun_q    <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                gain_q[i]  <= GAIN_RST;
                fgain_q[i] <= GAIN_RST;
                samp_q[i]  <= '0;
            end
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            acc_q       <= acc_d;
            out_valid_q <= (state_q == StOut);
            for (int i = 0; i < NUM_CH; i++) begin
                gain_q[i] <= gain_d[i];
            end
            // Snapshot takes gain_d so a write coincident with sample_ce lands in this frame.
            if (accept) begin
                fmute_q <= mute;
                for (int i = 0; i < NUM_CH; i++) begin
                    samp_q[i]  <= $signed(in_data[i*IN_W +: IN_W]);
                    fgain_q[i] <= gain_d[i];
                end
            end
            if (state_q == StOut) begin
                out_sample_q <= result;
            end
            clip_q    <= ((state_q == StOut) && sat) || (clip_q && !clr_flags);
            overrun_q <= ovr_event || (overrun_q && !clr_flags);
        end
    end

    assign out_sample = out_sample_q;
    assign out_valid  = out_valid_q;
    assign busy       = (state_q != StIdle);
    assign clip       = clip_q;
    assign overrun    = overrun_q;

endmodule
